serial_cmd_accumulator: RTL and testbench

//   Parametrised serial-command accumulator. Deserialises fixed-length commands
//   (LSB first) from a one-bit input, then executes each on an up/down

---
 rtl/serial_acc_pkg.sv | 30 +++
 rtl/serial_shift_rx.sv | 38 +++
 rtl/serial_cmd_accumulator.sv | 132 +++++++++++++
 tb/tb_serial_cmd_accumulator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_acc_pkg.sv
// Shared constants and types for the serial command accumulator.
// Frame length depends on SERIAL_ACC_PARITY_EN (adds one even-parity bit).
package serial_acc_pkg;

   localparam int CMD_BITS = 2;

`ifdef SERIAL_ACC_PARITY_EN
   localparam int FRAME_BITS = CMD_BITS + 1;
`else
   localparam int FRAME_BITS = CMD_BITS;
`endif

   localparam logic [CMD_BITS-1:0] CMD_NOP  = 2'b00;
   localparam logic [CMD_BITS-1:0] CMD_INC  = 2'b01;
   localparam logic [CMD_BITS-1:0] CMD_DEC  = 2'b10;
   localparam logic [CMD_BITS-1:0] CMD_LOAD = 2'b11;

   typedef enum logic {
      ST_SHIFT = 1'b0,
      ST_EXEC  = 1'b1
   } state_t;

`ifdef SERIAL_ACC_PARITY_EN
   // Even parity over the whole frame: command bits plus parity bit XOR to 0.
   function automatic logic frame_parity_ok(input logic [FRAME_BITS-1:0] f);
      return ~(^f);
   endfunction
`endif

endpackage

// File: rtl/serial_shift_rx.sv
// Serial frame receiver: LSB-first shift register with a bit counter.
// frame_ready flags the edge that captures the final bit of a frame.
module serial_shift_rx
   import serial_acc_pkg::*;
#(
   parameter int N = FRAME_BITS
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         shift_en,
   input  logic         clr,
   input  logic         control,
   output logic [N-1:0] frame,
   output logic         frame_ready
);

   localparam int CW = $clog2(N + 1);

   logic [N-1:0]  sr_q;
   logic [CW-1:0] cnt_q;

   // New bits enter at the MSB so the first bit received ends up in sr[0].
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (shift_en) begin
         sr_q  <= {control, sr_q[N-1:1]};
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign frame       = sr_q;
   assign frame_ready = shift_en && (cnt_q == CW'(N - 1));

endmodule

// File: rtl/serial_cmd_accumulator.sv
// Serial command accumulator: receives 2-bit commands (NOP/INC/DEC/LOAD) and
// applies them to ACC. Optional even-parity frame check via SERIAL_ACC_PARITY_EN.
//
//   state    | meaning
//   ST_SHIFT | collecting frame bits while ser_valid=1
//   ST_EXEC  | one cycle: decode frame, update ACC, input ignored
module serial_cmd_accumulator
   import serial_acc_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESET   = 8,
   parameter int SATURATE = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             control,
   input  logic             ser_valid,
   output logic [WIDTH-1:0] ACC,
   output logic             Zero,
   output logic             Max,
   output logic             busy,
   output logic             cmd_done,
   output logic             parity_err
);

   generate
      if (WIDTH < 2) begin : g_bad_width
         $error("serial_cmd_accumulator: WIDTH must be >= 2");
      end
      if (PRESET < 0 || PRESET >= (2 ** WIDTH)) begin : g_bad_preset
         $error("serial_cmd_accumulator: PRESET must fit in WIDTH bits");
      end
   endgenerate

   localparam logic [WIDTH-1:0] ACC_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ACC_PRE = WIDTH'(PRESET);

   state_t                  state_q, state_d;
   logic                    exec;
   logic                    shift_en;
   logic [FRAME_BITS-1:0]   frame;
   logic                    frame_ready;
   logic [CMD_BITS-1:0]     cmd;
   logic                    frame_ok;
   logic [WIDTH-1:0]        acc_q, acc_next;
   logic                    done_q;

   assign exec     = (state_q == ST_EXEC);
   assign shift_en = ser_valid && !exec;

   serial_shift_rx #(.N(FRAME_BITS)) u_rx (
      .CLK         (CLK),
      .RST         (RST),
      .shift_en    (shift_en),
      .clr         (exec),
      .control     (control),
      .frame       (frame),
      .frame_ready (frame_ready)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_SHIFT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SHIFT: if (frame_ready) state_d = ST_EXEC;
         ST_EXEC:  state_d = ST_SHIFT;
         default:  state_d = ST_SHIFT;
      endcase
   end

   assign cmd = frame[CMD_BITS-1:0];

`ifdef SERIAL_ACC_PARITY_EN
   assign frame_ok = frame_parity_ok(frame);
`else
   assign frame_ok = 1'b1;
`endif

   always_comb begin
      acc_next = acc_q;
      case (cmd)
         CMD_NOP:  acc_next = acc_q;
         CMD_INC:  begin
            if (SATURATE != 0 && acc_q == ACC_MAX) acc_next = acc_q;
            else                                   acc_next = acc_q + WIDTH'(1);
         end
         CMD_DEC:  begin
            if (SATURATE != 0 && acc_q == '0) acc_next = acc_q;
            else                              acc_next = acc_q - WIDTH'(1);
         end
         CMD_LOAD: acc_next = ACC_PRE;
         default:  acc_next = acc_q;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (exec && frame_ok) begin
            acc_q  <= acc_next;
            done_q <= 1'b1;
         end
      end
   end

`ifdef SERIAL_ACC_PARITY_EN
   logic perr_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) perr_q <= 1'b0;
      else     perr_q <= exec && !frame_ok;
   end

   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   assign ACC      = acc_q;
   assign Zero     = (acc_q == '0);
   assign Max      = (acc_q == ACC_MAX);
   assign busy     = exec;
   assign cmd_done = done_q;

endmodule

// File: tb/tb_serial_cmd_accumulator.sv
// Directed bench: a wrapping and a saturating instance share one serial stream.
module tb_serial_cmd_accumulator;

`ifdef SERIAL_ACC_PARITY_EN
   localparam int NB = 3;
`else
   localparam int NB = 2;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic       control;
   logic       ser_valid;

   logic [3:0] acc_w, acc_s;
   logic       zero_w, max_w, busy_w, done_w, perr_w;
   logic       zero_s, max_s, busy_s, done_s, perr_s;

   int checks = 0;
   int errors = 0;

   serial_cmd_accumulator #(.WIDTH(4), .PRESET(8), .SATURATE(0)) dut_wrap (
      .CLK(CLK), .RST(RST), .control(control), .ser_valid(ser_valid),
      .ACC(acc_w), .Zero(zero_w), .Max(max_w), .busy(busy_w),
      .cmd_done(done_w), .parity_err(perr_w)
   );

   serial_cmd_accumulator #(.WIDTH(4), .PRESET(8), .SATURATE(1)) dut_sat (
      .CLK(CLK), .RST(RST), .control(control), .ser_valid(ser_valid),
      .ACC(acc_s), .Zero(zero_s), .Max(max_s), .busy(busy_s),
      .cmd_done(done_s), .parity_err(perr_s)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_bit(input logic b, input int gap);
      control   = b;
      ser_valid = 1'b1;
      tick();
      ser_valid = 1'b0;
      control   = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_frame(input logic b0, input logic b1, input int gap);
      logic [2:0] bits;
      bits = {b0 ^ b1, b1, b0};
      for (int i = 0; i < NB; i++) send_bit(bits[i], (i == NB - 1) ? 0 : gap);
   endtask

   task automatic check_idle_reset(input string nm);
      checks++;
      if (acc_w !== 4'd0 || acc_s !== 4'd0 || zero_w !== 1'b1 || zero_s !== 1'b1 ||
          busy_w !== 1'b0 || busy_s !== 1'b0 || done_w !== 1'b0 || done_s !== 1'b0) begin
         errors++;
         $display("FAIL %s: acc=%0d/%0d zero=%b/%b busy=%b/%b done=%b/%b, want acc=0 zero=1 busy=0 done=0",
                  nm, acc_w, acc_s, zero_w, zero_s, busy_w, busy_s, done_w, done_s);
      end
   endtask

   task automatic do_cmd(input logic b0, input logic b1, input int gap, input bit junk,
                         input logic [3:0] ew, input logic [3:0] es, input string nm);
      send_frame(b0, b1, gap);
      checks++;
      if (busy_w !== 1'b1 || busy_s !== 1'b1 || done_w !== 1'b0) begin
         errors++;
         $display("FAIL %s exec_busy: busy=%b/%b done=%b, want busy=1 done=0", nm, busy_w, busy_s, done_w);
      end
      if (junk) begin
         ser_valid = 1'b1;
         control   = 1'b1;
      end
      tick();
      ser_valid = 1'b0;
      control   = 1'b0;
      checks++;
      if (acc_w !== ew) begin
         errors++;
         $display("FAIL %s acc_wrap: got %0d want %0d", nm, acc_w, ew);
      end
      checks++;
      if (acc_s !== es) begin
         errors++;
         $display("FAIL %s acc_sat: got %0d want %0d", nm, acc_s, es);
      end
      checks++;
      if (done_w !== 1'b1 || done_s !== 1'b1 || busy_w !== 1'b0 || perr_w !== 1'b0) begin
         errors++;
         $display("FAIL %s done: done=%b/%b busy=%b perr=%b, want done=1 busy=0 perr=0",
                  nm, done_w, done_s, busy_w, perr_w);
      end
      checks++;
      if (zero_w !== (ew == 4'd0) || max_w !== (ew == 4'd15) ||
          zero_s !== (es == 4'd0) || max_s !== (es == 4'd15)) begin
         errors++;
         $display("FAIL %s flags: zero=%b/%b max=%b/%b, want zero=%b/%b max=%b/%b", nm,
                  zero_w, zero_s, max_w, max_s, ew == 4'd0, es == 4'd0, ew == 4'd15, es == 4'd15);
      end
      tick();
      checks++;
      if (done_w !== 1'b0 || done_s !== 1'b0) begin
         errors++;
         $display("FAIL %s done_pulse: done=%b/%b one cycle later, want 0", nm, done_w, done_s);
      end
   endtask

   task automatic pulse_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      control = 1'b0;
      ser_valid = 1'b0;
      repeat (2) tick();
      check_idle_reset("reset_initial");
      RST = 1'b0;
      tick();
      do_cmd(1'b1, 1'b1, 0, 1'b0, 4'd8, 4'd8, "load_before_reset");
      send_bit(1'b1, 0);
      RST = 1'b1;
      #1;
      check_idle_reset("reset_mid_stream");
      tick();
      RST = 1'b0;
      do_cmd(1'b1, 1'b0, 0, 1'b0, 4'd1, 4'd1, "inc_after_reset");
   endtask

   task automatic test_load_dec();
      do_cmd(1'b1, 1'b1, 3, 1'b0, 4'd8, 4'd8, "load_gapped");
      do_cmd(1'b0, 1'b1, 3, 1'b0, 4'd7, 4'd7, "dec_gapped");
   endtask

   task automatic test_wrap();
      pulse_reset();
      for (int i = 1; i <= 16; i++)
         do_cmd(1'b1, 1'b0, 0, 1'b0, 4'(i % 16), (i > 15) ? 4'd15 : 4'(i), "inc_run");
      do_cmd(1'b0, 1'b1, 0, 1'b0, 4'd15, 4'd14, "dec_after_wrap");
      pulse_reset();
      do_cmd(1'b0, 1'b1, 0, 1'b0, 4'd15, 4'd0, "dec_at_zero");
   endtask

   task automatic test_exec_ignore();
      pulse_reset();
      do_cmd(1'b1, 1'b1, 0, 1'b1, 4'd8, 4'd8, "load_with_exec_junk");
      do_cmd(1'b1, 1'b0, 0, 1'b0, 4'd9, 4'd9, "inc_after_junk");
      do_cmd(1'b0, 1'b0, 1, 1'b0, 4'd9, 4'd9, "nop");
      send_bit(1'b1, 0);
      pulse_reset();
      do_cmd(1'b0, 1'b1, 0, 1'b0, 4'd15, 4'd0, "dec_after_midframe_reset");
   endtask

   task automatic test_reset_in_exec();
      send_frame(1'b1, 1'b0, 0);
      RST = 1'b1;
      #1;
      check_idle_reset("reset_in_exec");
      tick();
      RST = 1'b0;
      tick();
      check_idle_reset("after_reset_in_exec");
   endtask

`ifdef SERIAL_ACC_PARITY_EN
   task automatic test_parity();
      do_cmd(1'b1, 1'b0, 0, 1'b0, 4'd1, 4'd1, "inc_good_parity");
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      send_bit(1'b0, 0);
      tick();
      checks++;
      if (acc_w !== 4'd1 || acc_s !== 4'd1 || done_w !== 1'b0 || perr_w !== 1'b1 || perr_s !== 1'b1) begin
         errors++;
         $display("FAIL bad_parity: acc=%0d/%0d done=%b perr=%b/%b, want acc=1 done=0 perr=1",
                  acc_w, acc_s, done_w, perr_w, perr_s);
      end
      tick();
      checks++;
      if (perr_w !== 1'b0 || perr_s !== 1'b0) begin
         errors++;
         $display("FAIL parity_pulse: perr=%b/%b one cycle later, want 0", perr_w, perr_s);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load_dec();
      test_wrap();
      test_exec_ignore();
      test_reset_in_exec();
`ifdef SERIAL_ACC_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
